// File: rtl/skintone_v1_00_a_config_master_if.sv
// Config req/ack and opcode valid/accept bundle between the
// skintone config master and the datapath control ports.
interface skintone_v1_00_a_config_master_if;
  logic [35:0]  config_address;
  logic [127:0] config_datain;
  logic         config_wrreq;
  logic         config_rdreq;
  logic         config_wrack;
  logic         config_rdack;
  logic [127:0] config_dataout;
  logic [15:0]  opcode;
  logic         opcode_valid;
  logic         opcode_accept;

  modport master (
    output config_address,
    output config_datain,
    output config_wrreq,
    output config_rdreq,
    input  config_wrack,
    input  config_rdack,
    input  config_dataout,
    output opcode,
    output opcode_valid,
    input  opcode_accept
  );

  modport slave (
    input  config_address,
    input  config_datain,
    input  config_wrreq,
    input  config_rdreq,
    output config_wrack,
    output config_rdack,
    output config_dataout,
    input  opcode,
    input  opcode_valid,
    output opcode_accept
  );
endinterface

// File: rtl/skintone_v1_00_a_config_master.sv
// Skintone config master: writes the converter registers, optionally
// verifies them by readback, then issues one opcode.
module skintone_v1_00_a_config_master #(
  parameter int C_NUM_REGS    = 12,
  parameter int C_VERIFY      = 1,
  parameter int C_ACK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*C_NUM_REGS-1:0] coeff_in,
  input  logic [15:0]             opcode_in,
  skintone_v1_00_a_config_master_if.master cfg,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              error_code,
  output logic [3:0]              error_index
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, RD_REQ,
    RD_WAIT, OPC, FIN, ERR
  } state_t;

  localparam logic [3:0] LAST = 4'(C_NUM_REGS - 1);
  localparam logic [7:0] TMAX = 8'(C_ACK_TIMEOUT - 1);

  state_t       state;
  logic [3:0]   idx;
  logic [3:0]   nidx;
  logic [7:0]   tcnt;
  logic [127:0] coeff_pad;
  logic [127:0] coeff_q;
  logic [15:0]  opc_q;
  logic [7:0]   cur_val;
  logic [7:0]   nxt_val;
  logic         rd_ok;

  // padding to 16 slots keeps every index select in range
  assign coeff_pad = 128'(coeff_in);
  assign nidx      = idx + 4'd1;
  assign cur_val   = coeff_q[{idx, 3'b000} +: 8];
  assign nxt_val   = coeff_q[{nidx, 3'b000} +: 8];
  assign rd_ok     = cfg.config_dataout == {120'b0, cur_val};

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      idx                <= '0;
      tcnt               <= '0;
      coeff_q            <= '0;
      opc_q              <= '0;
      cfg.config_address <= '0;
      cfg.config_datain  <= '0;
      cfg.config_wrreq   <= 1'b0;
      cfg.config_rdreq   <= 1'b0;
      cfg.opcode         <= '0;
      cfg.opcode_valid   <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      error_code         <= '0;
      error_index        <= '0;
    end else begin
      cfg.config_wrreq <= 1'b0;
      cfg.config_rdreq <= 1'b0;
      done             <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            coeff_q            <= coeff_pad;
            opc_q              <= opcode_in;
            error              <= 1'b0;
            error_code         <= '0;
            error_index        <= '0;
            idx                <= '0;
            busy               <= 1'b1;
            cfg.config_wrreq   <= 1'b1;
            cfg.config_address <= '0;
            cfg.config_datain  <= {120'b0, coeff_pad[7:0]};
            state              <= WR_REQ;
          end
        end
        WR_REQ: begin
          tcnt  <= '0;
          state <= WR_WAIT;
        end
        WR_WAIT: begin
          if (cfg.config_wrack) begin
            if (idx != LAST) begin
              idx                <= nidx;
              cfg.config_wrreq   <= 1'b1;
              cfg.config_address <= {28'b0, nidx, 4'b0};
              cfg.config_datain  <= {120'b0, nxt_val};
              state              <= WR_REQ;
            end else if (C_VERIFY != 0) begin
              idx                <= '0;
              cfg.config_rdreq   <= 1'b1;
              cfg.config_address <= '0;
              state              <= RD_REQ;
            end else begin
              cfg.opcode       <= opc_q;
              cfg.opcode_valid <= 1'b1;
              tcnt             <= '0;
              state            <= OPC;
            end
          end else if (tcnt == TMAX) begin
            error       <= 1'b1;
            error_code  <= 2'b01;
            error_index <= idx;
            state       <= ERR;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        RD_REQ: begin
          tcnt  <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (cfg.config_rdack) begin
            if (!rd_ok) begin
              error       <= 1'b1;
              error_code  <= 2'b10;
              error_index <= idx;
              state       <= ERR;
            end else if (idx != LAST) begin
              idx                <= nidx;
              cfg.config_rdreq   <= 1'b1;
              cfg.config_address <= {28'b0, nidx, 4'b0};
              state              <= RD_REQ;
            end else begin
              cfg.opcode       <= opc_q;
              cfg.opcode_valid <= 1'b1;
              tcnt             <= '0;
              state            <= OPC;
            end
          end else if (tcnt == TMAX) begin
            error       <= 1'b1;
            error_code  <= 2'b01;
            error_index <= idx;
            state       <= ERR;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        OPC: begin
          if (cfg.opcode_accept) begin
            cfg.opcode_valid <= 1'b0;
            done             <= 1'b1;
            state            <= FIN;
          end else if (tcnt == TMAX) begin
            cfg.opcode_valid <= 1'b0;
            error            <= 1'b1;
            error_code       <= 2'b01;
            error_index      <= 4'hF;
            state            <= ERR;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skintone_v1_00_a_config_master.sv
// Directed-plus-random bench for the skintone config master with a
// behavioural register-file responder and timing model.
module tb_skintone_v1_00_a_config_master;
  localparam int N = 12;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_nv = 1'b0;
  logic [8*N-1:0] coeff_in = '0;
  logic [15:0] opcode_in = '0;
  logic busy, done, error;
  logic [1:0] error_code;
  logic [3:0] error_index;
  logic busy_nv, done_nv, error_nv;
  logic [1:0] ec_nv;
  logic [3:0] ei_nv;

  skintone_v1_00_a_config_master_if b ();
  skintone_v1_00_a_config_master_if n ();

  skintone_v1_00_a_config_master #(
    .C_NUM_REGS(N), .C_VERIFY(1), .C_ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .coeff_in(coeff_in), .opcode_in(opcode_in),
    .cfg(b), .busy(busy), .done(done), .error(error),
    .error_code(error_code), .error_index(error_index)
  );

  skintone_v1_00_a_config_master #(
    .C_NUM_REGS(N), .C_VERIFY(0), .C_ACK_TIMEOUT(TO)
  ) dut_nv (
    .clk(clk), .rst(rst), .start(start_nv),
    .coeff_in(coeff_in), .opcode_in(opcode_in),
    .cfg(n), .busy(busy_nv), .done(done_nv), .error(error_nv),
    .error_code(ec_nv), .error_index(ei_nv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int t0 = 0;

  // responder knobs and logs
  bit no_ack_en = 0;
  int no_ack_idx = 0;
  bit corrupt_en = 0;
  int corrupt_idx = 0;
  int acc_delay = 1;
  bit never_acc = 0;
  logic [35:0] wr_addr[$];
  logic [127:0] wr_data[$];
  int rd_cnt = 0, valid_cycles = 0, acc_cnt = 0;
  int done_cnt = 0, dbl_req = 0, vcnt = 0;
  logic [15:0] acc_opc = '0, first_opc = '0;
  bit opc_unstable = 0;
  bit prev_wr = 0, prev_rd = 0;
  logic [3:0] prev_widx = '0, prev_ridx = '0;
  logic [7:0] prev_wdata = '0;
  logic [7:0] mem [16];

  always @(posedge clk) begin
    #1;
    b.config_wrack = 1'b0;
    b.config_rdack = 1'b0;
    b.opcode_accept = 1'b0;
    b.config_dataout = '0;
    if (prev_wr && !(no_ack_en && int'(prev_widx) == no_ack_idx)) begin
      b.config_wrack = 1'b1;
      mem[prev_widx] = prev_wdata;
    end
    if (prev_rd) begin
      b.config_rdack = 1'b1;
      if (corrupt_en && int'(prev_ridx) == corrupt_idx)
        b.config_dataout = 128'hFF;
      else
        b.config_dataout = {120'b0, mem[prev_ridx]};
    end
    if (b.config_wrreq === 1'b1) begin
      if (prev_wr) dbl_req++;
      wr_addr.push_back(b.config_address);
      wr_data.push_back(b.config_datain);
    end
    if (b.config_rdreq === 1'b1) begin
      if (prev_rd) dbl_req++;
      rd_cnt++;
    end
    prev_wr = (b.config_wrreq === 1'b1);
    prev_rd = (b.config_rdreq === 1'b1);
    prev_widx = b.config_address[7:4];
    prev_ridx = b.config_address[7:4];
    prev_wdata = b.config_datain[7:0];
    if (b.opcode_valid === 1'b1) begin
      if (vcnt == 0) first_opc = b.opcode;
      else if (b.opcode !== first_opc) opc_unstable = 1;
      vcnt++;
      valid_cycles++;
      if (!never_acc && vcnt == acc_delay + 1) begin
        b.opcode_accept = 1'b1;
        acc_cnt++;
        acc_opc = b.opcode;
      end
    end else begin
      vcnt = 0;
    end
    if (done === 1'b1) done_cnt++;
  end

  int rd_nv = 0, wr_nv = 0, vc_nv = 0;
  bit pw_nv = 0, pr_nv = 0;
  always @(posedge clk) begin
    #1;
    n.config_wrack = pw_nv;
    n.config_rdack = pr_nv;
    n.config_dataout = '0;
    n.opcode_accept = 1'b0;
    pw_nv = (n.config_wrreq === 1'b1);
    pr_nv = (n.config_rdreq === 1'b1);
    if (pw_nv) wr_nv++;
    if (pr_nv) rd_nv++;
    if (n.opcode_valid === 1'b1) begin
      vc_nv++;
      if (vc_nv == 2) n.opcode_accept = 1'b1;
    end else begin
      vc_nv = 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_done(int passes, int acc);
    return 1 + 2 * N * passes + acc + 1;
  endfunction

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    rd_cnt = 0;
    valid_cycles = 0;
    acc_cnt = 0;
    done_cnt = 0;
    dbl_req = 0;
    opc_unstable = 0;
  endtask

  task automatic start_run(input logic [8*N-1:0] c,
                           input logic [15:0] o);
    coeff_in = c;
    opcode_in = o;
    clear_logs();
    start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int endc);
    endc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1 || error === 1'b1) begin
        endc = cyc - t0;
        break;
      end
      step();
    end
    chk("end_reached", 128'(endc >= 0), 128'd1);
    chk("busy_last", 128'(busy), 128'd1);
    step();
    chk("busy_fall", 128'(busy), 128'd0);
  endtask

  task automatic check_writes(input logic [8*N-1:0] c, input int cnt);
    int m;
    chk("wr_count", 128'(wr_addr.size()), 128'(cnt));
    m = (wr_addr.size() < cnt) ? wr_addr.size() : cnt;
    for (int i = 0; i < m; i++) begin
      chk("wr_addr", 128'(wr_addr[i]), 128'(i * 16));
      chk("wr_data", wr_data[i], 128'(c[8*i +: 8]));
    end
  endtask

  function automatic logic [8*N-1:0] ramp();
    logic [8*N-1:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = 8'(8'h10 + i);
    return v;
  endfunction

  function automatic logic [8*N-1:0] rnd_coeff();
    logic [8*N-1:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  initial begin
    int e;
    logic [8*N-1:0] ca;
    logic [8*N-1:0] cb;
    logic [15:0] op;

    repeat (3) step();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_error", 128'(error), 128'd0);
    chk("rst_code", 128'(error_code), 128'd0);
    chk("rst_index", 128'(error_index), 128'd0);
    chk("rst_wrreq", 128'(b.config_wrreq), 128'd0);
    chk("rst_rdreq", 128'(b.config_rdreq), 128'd0);
    chk("rst_valid", 128'(b.opcode_valid), 128'd0);
    chk("rst_addr", 128'(b.config_address), 128'd0);
    chk("rst_datain", b.config_datain, 128'd0);
    chk("rst_opcode", 128'(b.opcode), 128'd0);
    rst = 1'b0;
    step();

    // nominal
    ca = ramp();
    acc_delay = 1;
    start_run(ca, 16'h00A5);
    wait_end(200, e);
    chk("nom_done_cyc", 128'(e), 128'(exp_done(2, 1)));
    chk("nom_error", 128'(error), 128'd0);
    chk("nom_code", 128'(error_code), 128'd0);
    check_writes(ca, N);
    chk("nom_reads", 128'(rd_cnt), 128'(N));
    chk("nom_opc", 128'(acc_opc), 128'h00A5);
    chk("nom_acc", 128'(acc_cnt), 128'd1);
    chk("nom_donecnt", 128'(done_cnt), 128'd1);
    chk("nom_dblreq", 128'(dbl_req), 128'd0);

    // random coefficients, opcodes and accept latency
    for (int r = 0; r < 3; r++) begin
      ca = rnd_coeff();
      op = 16'($urandom_range(0, 65535));
      acc_delay = $urandom_range(1, 6);
      start_run(ca, op);
      wait_end(200, e);
      chk("rnd_done_cyc", 128'(e), 128'(exp_done(2, acc_delay)));
      check_writes(ca, N);
      chk("rnd_reads", 128'(rd_cnt), 128'(N));
      chk("rnd_opc", 128'(acc_opc), 128'(op));
      chk("rnd_vcycles", 128'(valid_cycles), 128'(acc_delay + 1));
      chk("rnd_stable", 128'(opc_unstable), 128'd0);
      chk("rnd_error", 128'(error), 128'd0);
    end
    acc_delay = 1;

    // readback mismatch on register 7
    ca = ramp();
    corrupt_en = 1;
    corrupt_idx = 7;
    start_run(ca, 16'h1234);
    wait_end(200, e);
    corrupt_en = 0;
    chk("mm_err_cyc", 128'(e), 128'(1 + 2 * N + 2 * 7 + 2));
    chk("mm_error", 128'(error), 128'd1);
    chk("mm_code", 128'(error_code), 128'd2);
    chk("mm_index", 128'(error_index), 128'd7);
    chk("mm_valid", 128'(valid_cycles), 128'd0);
    chk("mm_donecnt", 128'(done_cnt), 128'd0);

    // write of index 3 never acknowledged
    ca = rnd_coeff();
    no_ack_en = 1;
    no_ack_idx = 3;
    start_run(ca, 16'h4321);
    wait_end(200, e);
    no_ack_en = 0;
    chk("wto_err_cyc", 128'(e), 128'(1 + 2 * 3 + 1 + TO));
    chk("wto_code", 128'(error_code), 128'd1);
    chk("wto_index", 128'(error_index), 128'd3);
    chk("wto_donecnt", 128'(done_cnt), 128'd0);
    check_writes(ca, 4);
    chk("wto_reads", 128'(rd_cnt), 128'd0);

    // opcode stalled by 5 cycles
    ca = rnd_coeff();
    acc_delay = 5;
    start_run(ca, 16'hBEEF);
    wait_end(200, e);
    chk("stall_done_cyc", 128'(e), 128'(exp_done(2, 5)));
    chk("stall_vcycles", 128'(valid_cycles), 128'd6);
    chk("stall_stable", 128'(opc_unstable), 128'd0);
    chk("stall_opc", 128'(acc_opc), 128'hBEEF);
    chk("stall_error", 128'(error), 128'd0);
    acc_delay = 1;

    // opcode never accepted
    never_acc = 1;
    start_run(ca, 16'h0F0F);
    wait_end(200, e);
    never_acc = 0;
    chk("oto_err_cyc", 128'(e), 128'(1 + 2 * N * 2 + TO));
    chk("oto_code", 128'(error_code), 128'd1);
    chk("oto_index", 128'(error_index), 128'd15);
    chk("oto_vcycles", 128'(valid_cycles), 128'(TO));
    chk("oto_donecnt", 128'(done_cnt), 128'd0);

    // second start while busy is ignored; sticky error clears
    ca = rnd_coeff();
    cb = ~ca;
    start_run(ca, 16'h5555);
    chk("clr_error", 128'(error), 128'd0);
    chk("clr_code", 128'(error_code), 128'd0);
    repeat (4) step();
    coeff_in = cb;
    opcode_in = 16'hAAAA;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_end(200, e);
    chk("bsy_done_cyc", 128'(e), 128'(exp_done(2, 1)));
    check_writes(ca, N);
    chk("bsy_opc", 128'(acc_opc), 128'h5555);
    chk("bsy_donecnt", 128'(done_cnt), 128'd1);

    // reset at cycle 10 aborts, then a fresh run completes
    start_run(ca, 16'h7777);
    for (int i = 0; i < 40 && (cyc - t0) < 10; i++) step();
    rst = 1'b1;
    step();
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_wrreq", 128'(b.config_wrreq), 128'd0);
    chk("mid_rst_rdreq", 128'(b.config_rdreq), 128'd0);
    chk("mid_rst_valid", 128'(b.opcode_valid), 128'd0);
    chk("mid_rst_addr", 128'(b.config_address), 128'd0);
    chk("mid_rst_datain", b.config_datain, 128'd0);
    chk("mid_rst_opcode", 128'(b.opcode), 128'd0);
    chk("mid_rst_flags", 128'({done, error, error_code, error_index}), 128'd0);
    rst = 1'b0;
    cb = rnd_coeff();
    start_run(cb, 16'h0101);
    wait_end(200, e);
    chk("post_rst_cyc", 128'(e), 128'(exp_done(2, 1)));
    check_writes(cb, N);
    chk("post_rst_opc", 128'(acc_opc), 128'h0101);

    // no-verify instance
    coeff_in = ramp();
    opcode_in = 16'h00A5;
    rd_nv = 0;
    wr_nv = 0;
    start_nv = 1'b1;
    t0 = cyc;
    step();
    start_nv = 1'b0;
    e = -1;
    for (int i = 0; i < 200; i++) begin
      if (done_nv === 1'b1) begin
        e = cyc - t0;
        break;
      end
      step();
    end
    chk("nv_done_cyc", 128'(e), 128'(exp_done(1, 1)));
    chk("nv_reads", 128'(rd_nv), 128'd0);
    chk("nv_writes", 128'(wr_nv), 128'(N));
    chk("nv_error", 128'(error_nv), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
